// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared encodings for the HI/LO multiply/divide unit
package hilo_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Operation select; op[1] picks divide, op[0] picks unsigned
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Sequencer states
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_FIX  = 2'b10;

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div_op(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// rtl/hilo_muldiv_unit_if.sv - issue/MT-write/result bundle of the multiply/divide unit
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] mt_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    // Pipeline side issues operations and reads HI/LO
    modport master (
        output start, op, rs_val, rt_val, mthi, mtlo, mt_data,
        input  hi, lo, busy, done
    );

    // The unit itself
    modport slave (
        input  start, op, rs_val, rt_val, mthi, mtlo, mt_data,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add or restoring shift-subtract iteration
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Multiply: acc = {partial product, remaining multiplier bits}, add then shift right.
    // Divide: acc = {partial remainder, remaining dividend bits}, shift left then trial subtract.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = shifted - {1'b0, operand};
        acc_next = {sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (!diff[WIDTH]) begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU engine owning HI and LO
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    hilo_muldiv_unit_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [1:0]         state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [2*WIDTH-1:0] acc_q,     acc_d;
    logic [WIDTH-1:0]   operand_q, operand_d;
    logic [WIDTH-1:0]   rs_raw_q,  rs_raw_d;
    logic               is_div_q,  is_div_d;
    logic               neg_a_q,   neg_a_d;
    logic               neg_b_q,   neg_b_d;
    logic               dbz_q,     dbz_d;
    logic [WIDTH-1:0]   hi_q,      hi_d;
    logic [WIDTH-1:0]   lo_q,      lo_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    logic [2*WIDTH-1:0] step_acc;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div_q),
        .acc      (acc_q),
        .operand  (operand_q),
        .acc_next (step_acc)
    );

    // Next-state: operand capture in IDLE, one iteration per RUN cycle, sign fix and write-back in FIX
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        operand_d = operand_q;
        rs_raw_d  = rs_raw_q;
        is_div_d  = is_div_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        dbz_d     = dbz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        a_neg = is_signed_op(bus.op) & bus.rs_val[WIDTH-1];
        b_neg = is_signed_op(bus.op) & bus.rt_val[WIDTH-1];
        a_mag = a_neg ? -bus.rs_val : bus.rs_val;
        b_mag = b_neg ? -bus.rt_val : bus.rt_val;

        prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // The multiplier (or dividend) sits in the low half and is consumed bit by bit
                    is_div_d  = is_div_op(bus.op);
                    neg_a_d   = a_neg;
                    neg_b_d   = b_neg;
                    dbz_d     = is_div_op(bus.op) && (bus.rt_val == '0);
                    rs_raw_d  = bus.rs_val;
                    operand_d = is_div_op(bus.op) ? b_mag : a_mag;
                    acc_d     = {{WIDTH{1'b0}}, (is_div_op(bus.op) ? a_mag : b_mag)};
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = S_RUN;
                end else begin
                    if (bus.mthi) hi_d = bus.mt_data;
                    if (bus.mtlo) lo_d = bus.mt_data;
                end
            end
            S_RUN: begin
                acc_d = step_acc;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (dbz_q) begin
                    hi_d = rs_raw_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset discards any in-flight operation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            operand_q <= '0;
            rs_raw_q  <= '0;
            is_div_q  <= 1'b0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            operand_q <= operand_d;
            rs_raw_q  <= rs_raw_d;
            is_div_q  <= is_div_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            dbz_q     <= dbz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - vector table plus corner sequences with a result scoreboard
module tb_hilo_muldiv_unit;
    import hilo_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total  = 0;
    int   passed = 0;
    exp_t sb[$];
    logic [31:0] model_hi, model_lo;
    vec_t vecs[11];

    hilo_muldiv_unit_if #(.WIDTH(32)) bus ();

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Scoreboard: every done pops one expected result
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (sb.size() == 0) begin
                chk("done_without_pending_op", 64'(bus.done), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("%s_hi", e.name), 64'(bus.hi), 64'(e.hi));
                chk($sformatf("%s_lo", e.name), 64'(bus.lo), 64'(e.lo));
            end
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input string name,
                          input bit mt_with_start, input int disturb);
        int lat;
        int busy_bad;
        bit got;
        exp_t e;
        e.hi = ehi; e.lo = elo; e.name = name;
        sb.push_back(e);
        bus.op = op; bus.rs_val = a; bus.rt_val = b; bus.start = 1'b1;
        if (mt_with_start) begin
            bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.mt_data = 32'hA5A5_A5A5;
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        lat = 0; busy_bad = 0; got = 1'b0;
        for (int k = 1; k <= 60 && !got; k++) begin
            @(negedge clk);
            if (k == disturb) begin
                bus.start = 1'b1; bus.op = OP_MULTU;
                bus.rs_val = 32'hFFFF_FFFF; bus.rt_val = 32'hFFFF_FFFF;
                bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.mt_data = 32'hDEAD_BEEF;
            end else if (disturb != 0 && k == disturb + 1) begin
                bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
            end
            if (k <= 33 && !bus.busy) busy_bad++;
            if (k == 33) begin
                chk($sformatf("%s_hold_hi", name), 64'(bus.hi), 64'(model_hi));
                chk($sformatf("%s_hold_lo", name), 64'(bus.lo), 64'(model_lo));
            end
            if (bus.done) begin
                got = 1'b1;
                lat = k;
                chk($sformatf("%s_busy_low_at_done", name), 64'(bus.busy), 64'd0);
            end
        end
        chk($sformatf("%s_latency", name), 64'(lat), 64'd34);
        chk($sformatf("%s_busy_cycles_low", name), 64'(busy_bad), 64'd0);
        model_hi = ehi;
        model_lo = elo;
    endtask

    initial begin
        vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
        vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7"};
        vecs[2]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minsq"};
        vecs[3]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2"};
        vecs[4]  = '{OP_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, "divu_7by2"};
        vecs[5]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_overflow"};
        vecs[6]  = '{OP_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, "divu_by0"};
        vecs[7]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_by0"};
        vecs[8]  = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7bym2"};
        vecs[9]  = '{OP_MULT,  32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hEDCB_A988, "mult_negate"};
        vecs[10] = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, "multu_carry"};

        reset = 1'b1;
        bus.start = 1'b0; bus.op = OP_MULT; bus.rs_val = '0; bus.rt_val = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.mt_data = '0;
        model_hi = '0; model_lo = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_hi", 64'(bus.hi), 64'd0);
        chk("reset_lo", 64'(bus.lo), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        reset = 1'b0;

        // Direct HI/LO writes in IDLE, separately and together
        bus.mthi = 1'b1; bus.mt_data = 32'h1234_5678;
        @(posedge clk); #1 bus.mthi = 1'b0;
        @(negedge clk);
        chk("mthi_hi", 64'(bus.hi), 64'h1234_5678);
        chk("mthi_lo_untouched", 64'(bus.lo), 64'd0);
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.mt_data = 32'h0BAD_F00D;
        @(posedge clk); #1 begin bus.mthi = 1'b0; bus.mtlo = 1'b0; end
        @(negedge clk);
        chk("mtboth_hi", 64'(bus.hi), 64'h0BAD_F00D);
        chk("mtboth_lo", 64'(bus.lo), 64'h0BAD_F00D);
        model_hi = 32'h0BAD_F00D; model_lo = 32'h0BAD_F00D;

        // Table of operations issued back to back
        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, vecs[i].name, 1'b0, 0);

        // Start outranks MTHI/MTLO in the same cycle
        run_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "start_beats_mt", 1'b1, 0);

        // MTLO/MTHI/start during RUN are dropped
        run_op(OP_MULTU, 32'd6, 32'd9, 32'd0, 32'd54, "ignore_while_busy", 1'b0, 5);
        repeat (40) @(negedge clk);
        chk("no_queued_start_busy", 64'(bus.busy), 64'd0);

        // Reset in the middle of RUN
        bus.op = OP_MULTU; bus.rs_val = 32'hFFFF_FFFF; bus.rt_val = 32'd2; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrun_reset_hi", 64'(bus.hi), 64'd0);
        chk("midrun_reset_lo", 64'(bus.lo), 64'd0);
        chk("midrun_reset_busy", 64'(bus.busy), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        model_hi = '0; model_lo = '0;
        repeat (40) @(negedge clk);
        chk("after_reset_idle_busy", 64'(bus.busy), 64'd0);
        run_op(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, "multu_after_reset", 1'b0, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
